fetch_unit: RTL

- Fetch stage directly upstream of the Fetch/Decode pipeline register.
- Generates the PC and issues requests to instruction memory, which may have variable latency.
- Buffers in-order responses in a small queue and presents InstrF, PCF and PCPlus4F, qualified by InstrValidF.
- Honours StallF and branch/jump redirects; responses already in flight for squashed fetches are discarded.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/fetch_unit.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
// Entries carry an instruction together with the PC it was fetched from.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam int FETCH_DEPTH = 2;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP = 32'b0;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with flush and occupancy count.
// Storage is unreset; the head is only meaningful while not empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t wrData,
  output fetch_entry_t rdData,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);

  fetch_entry_t mem [DEPTH];

  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;
  logic          doPush;
  logic          doPop;

  function automatic logic [PW-1:0] bump(
    input logic [PW-1:0] p
  );
    if (p == PW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign doPop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign doPush = push & (~full | doPop);
  assign rdData = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= bump(wrPtr);
      if (doPop)  rdPtr <= bump(rdPtr);
      if (doPush && !doPop) begin
        count <= count + 1'b1;
      end else if (doPop && !doPush) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= wrData;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC generation, instruction memory requests and an
// in-order response buffer feeding the Fetch/Decode register.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int N = XLEN,
  parameter int DEPTH = FETCH_DEPTH,
  parameter logic [N-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         StallF,
  input  logic         Redirect,
  input  logic [N-1:0] RedirectPC,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ready,
  input  logic         imem_rvalid,
  input  logic [N-1:0] imem_rdata,
  output logic [N-1:0] InstrF,
  output logic [N-1:0] PCF,
  output logic [N-1:0] PCPlus4F,
  output logic         InstrValidF
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [N-1:0]  fetchPc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] outNext;
  logic [CW-1:0] occupancy;
  logic [CW-1:0] tagCount;
  logic [CW:0]   inUse;

  logic accept;
  logic rspOk;
  logic rspKeep;
  logic consume;

  fetch_entry_t bufIn;
  fetch_entry_t bufHead;
  fetch_entry_t tagIn;
  fetch_entry_t tagHead;

  logic bufFull;
  logic bufEmpty;
  logic tagFull;
  logic tagEmpty;
  logic unusedTag;

  // Requests in flight plus buffered entries never exceed DEPTH,
  // so every response always has a free buffer slot.
  assign inUse    = {1'b0, occupancy} + {1'b0, outstanding};
  assign imem_req = rst & ~Redirect &
                    (inUse < (CW + 1)'(DEPTH));
  assign imem_addr = fetchPc;

  assign accept  = imem_req & imem_ready;
  assign rspOk   = rst & imem_rvalid & (outstanding != '0);
  assign rspKeep = rspOk & ~Redirect & (discard == '0);
  assign consume = InstrValidF & ~StallF & ~Redirect;

  always_comb begin
    outNext = outstanding;
    if (accept && !rspOk) begin
      outNext = outstanding + 1'b1;
    end else if (rspOk && !accept) begin
      outNext = outstanding - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetchPc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outNext;
      if (Redirect) begin
        fetchPc <= RedirectPC;
        // Everything still in flight after this edge is stale.
        discard <= outNext;
      end else begin
        if (accept) fetchPc <= fetchPc + N'(4);
        if (rspOk && discard != '0) begin
          discard <= discard - 1'b1;
        end
      end
    end
  end

  assign tagIn.instr = NOP;
  assign tagIn.pc    = fetchPc;

  fetch_fifo #(.DEPTH(DEPTH)) tagQ (
    .clk    (clk),
    .rst    (rst),
    .flush  (1'b0),
    .push   (accept),
    .pop    (rspOk),
    .wrData (tagIn),
    .rdData (tagHead),
    .full   (tagFull),
    .empty  (tagEmpty),
    .count  (tagCount)
  );

  assign bufIn.instr = imem_rdata;
  assign bufIn.pc    = tagHead.pc;

  fetch_fifo #(.DEPTH(DEPTH)) instrBuf (
    .clk    (clk),
    .rst    (rst),
    .flush  (Redirect),
    .push   (rspKeep),
    .pop    (consume),
    .wrData (bufIn),
    .rdData (bufHead),
    .full   (bufFull),
    .empty  (bufEmpty),
    .count  (occupancy)
  );

  assign unusedTag = ^{tagFull, tagEmpty, tagCount,
                       tagHead.instr, bufFull};

  assign InstrValidF = ~bufEmpty;
  assign InstrF   = InstrValidF ? bufHead.instr : NOP;
  assign PCF      = InstrValidF ? bufHead.pc : '0;
  assign PCPlus4F = InstrValidF ? bufHead.pc + N'(4) : '0;

  a_rvalidIdle: assert property (
    @(posedge clk) disable iff (!rst)
    !(imem_rvalid && outstanding == '0)
  );

endmodule
